seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display. It is the consumer of the modulo up/down digit counters: it reads their packed count values and scans them onto shared segment lines, one digit at a time. Each digit slot has a blanking gap to suppress ghosting. All inputs are snapshotted once per frame so that a display frame never tears.

## Interface
Parameters:
- DIGITS, 4: number of digits; 4-bit value each.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock; no other reset.
- en  in  1  scan enable; low blanks the display and freezes the scan.
- digits_in  in  4*DIGITS  packed digit values; digit 0 occupies [3:0] and is the rightmost digit.
- dp_in  in  DIGITS  decimal-point request per digit, active-high.
- blank_lz  in  1  leading-zero blanking enable.
- anode  out  DIGITS  digit select, active-low.
- seg  out  7  segments a..g on seg[0]..seg[6], active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a new snapshot is in use.

## Operation
- State: prescaler cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1), and snapshot registers snap_dig and snap_dp.
- Phase is BLANK when cnt < BLANK_CYCLES and DRIVE otherwise. The phase is derived from cnt; there is no separate phase register.
- When en=1, cnt increments every cycle.
  - On cnt = REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps DIGITS-1 → 0.
- Snapshot load:
  - snap_dig and snap_dp load from digits_in and dp_in on the edge where both cnt and idx wrap to 0.
  - They also load on the first enabled edge after reset.
  - Changes to digits_in mid-frame have no effect until the next load.
- In BLANK: anode is all ones, seg = 7'h7F, dp = 1.
- In DRIVE: anode[idx] = 0 and all other anode bits are 1. seg shows the glyph for snap_dig[idx]; dp = ~snap_dp[idx].
- Glyphs are hex 0-F.
  - 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - A, b, C, d, E, F use the standard forms.
- Leading-zero blanking (blank_lz=1): a digit is blanked if it and every higher-index digit are zero in the snapshot.
  - "Blanked" means seg = 7'h7F. The anode is still driven, and dp still follows snap_dp.
  - Digit 0 is never blanked.
- en=0: anode, seg and dp go to the off values. cnt, idx and the snapshot hold. On re-enable, scanning resumes from the held cnt and idx.

## Timing
- Reset values: anode all ones, seg 7'h7F, dp 1, frame_start 0, cnt 0, idx 0, snapshot 0, snapshot-valid flag 0.
- anode, seg and dp are registered. In any cycle they reflect the cnt, idx and snapshot values registered in that same cycle. This means next-state logic also drives the output registers; there is no extra latency stage.
- frame_start is high for exactly the one cycle after each snapshot load edge. It is also high after the first post-reset load.
- Full frame period: DIGITS × REFRESH_DIV cycles. Per-digit on-time: REFRESH_DIV − BLANK_CYCLES cycles.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously); no partial glyph remains.
- en falling in DRIVE: the display is dark from the next edge. If en falls on a wrap edge, that edge neither advances state nor loads a snapshot.

## Structure
- Shared package seven_seg_pkg:
  - segment glyph constants for 0-F;
  - SEG_OFF = 7'h7F;
  - the segment bit-order definition.
- One sub-module: seg_decoder, combinational. Maps a 4-bit value plus a blank flag to 7 active-low segments. The top level instantiates it once, after the idx mux.
- Top level holds the prescaler, the idx counter, the snapshot, the leading-zero logic and the output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset release with digits_in=16'h1234, en=1, blank_lz=0:
  - frame_start pulses once;
  - anode=4'b1111 for 2 cycles, then 4'b1110 with seg=7'b0011001 ("4") for 6 cycles;
  - then digit 1 shows "3"; full frame is 32 cycles.
- Change digits_in from 16'h1234 to 16'h5678 during digit 2 of a frame: the remaining slots of that frame still show 2 and 1. The next frame shows 8 first, and frame_start pulses at the frame boundary.
- digits_in=16'h0050, dp_in=4'b0010, blank_lz=1:
  - digits 3 and 2 have seg=7'h7F with anode active;
  - digit 1 shows "5" with dp=0;
  - digit 0 shows "0".
  - With 16'h0000, only digit 0 lights, showing "0".
- en=0 for 5 cycles while cnt=4, idx=1: anode=4'b1111 throughout. On re-enable, anode=4'b1101 and continues for exactly the remaining cycles, through cnt=7.
- Assert reset at cnt=5, idx=2: anode=4'b1111, seg=7'h7F and dp=1 within the same cycle, with no clock edge. After release, the scan restarts at idx 0 with a fresh snapshot.
- Sweep digit values 0-F through digit 0: seg matches each package glyph, including A=7'b0001000 and F=7'b0001110.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scanner: segment bit order, glyph table
// (active-low, seg[0]=a .. seg[6]=g) and the slot phase type.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Written as 7'bgfedcba; index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seven_seg_scanner_seg_decoder.sv
// Combinational hex-to-segment decoder with a blank override; active-low outputs.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : SEG_GLYPHS[value];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver with per-slot blanking gap,
// per-frame input snapshot and optional leading-zero suppression.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*DIGITS-1:0]   snap_dig, snap_dig_nx;
  logic [DIGITS-1:0]     snap_dp, snap_dp_nx;
  logic                  snap_valid;
  logic                  load;
  logic                  cnt_wrap;
  phase_e                phase_nx;
  logic                  drive_nx;
  logic [3:0]            val_nx;
  logic                  lz_nx;
  logic                  dp_nx;
  logic [DIGITS-1:0]     anode_nx;
  logic [6:0]            seg_dec;

  // Outputs are decoded from next-state values so the registered display
  // matches the registered cnt/idx/snapshot in the same cycle.
  always_comb begin
    cnt_nx      = cnt;
    idx_nx      = idx;
    snap_dig_nx = snap_dig;
    snap_dp_nx  = snap_dp;
    load        = 1'b0;
    cnt_wrap    = (cnt == CW'(REFRESH_DIV - 1));
    if (en) begin
      if (cnt_wrap) begin
        cnt_nx = '0;
        idx_nx = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt_nx = cnt + CW'(1);
      end
      load = !snap_valid || (cnt_wrap && (idx == IW'(DIGITS - 1)));
      if (load) begin
        snap_dig_nx = digits_in;
        snap_dp_nx  = dp_in;
      end
    end

    phase_nx = (cnt_nx < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
    drive_nx = en && (phase_nx == PH_DRIVE);
    val_nx   = snap_dig_nx[4*idx_nx +: 4];
    dp_nx    = ~snap_dp_nx[idx_nx];

    lz_nx = blank_lz && (idx_nx != '0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((i >= 32'(idx_nx)) && (snap_dig_nx[4*i +: 4] != 4'h0)) begin
        lz_nx = 1'b0;
      end
    end

    anode_nx = '1;
    if (drive_nx) begin
      anode_nx[idx_nx] = 1'b0;
    end
  end

  seg_decoder u_dec (
    .value (val_nx),
    .blank (!drive_nx || lz_nx),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      snap_dig    <= '0;
      snap_dp     <= '0;
      snap_valid  <= 1'b0;
      anode       <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      snap_dig    <= snap_dig_nx;
      snap_dp     <= snap_dp_nx;
      snap_valid  <= snap_valid | load;
      anode       <= anode_nx;
      seg         <= seg_dec;
      dp          <= drive_nx ? dp_nx : 1'b1;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_seven_seg_scanner;

  localparam int D = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = D * R;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position k = enabled edges since reset.
  int unsigned k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_dig = '0; m_dp = '0;
    e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned pos, slot, c;
    logic [15:0] hi;
    e_fs = 1'b0; e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (en) begin
      k++;
      e_fs = (k == 1) || (k % FRAME == 0);
      if (e_fs) begin
        m_dig = digits_in;
        m_dp  = dp_in;
      end
      pos  = k % FRAME;
      slot = pos / R;
      c    = pos % R;
      if (c >= B) begin
        e_anode[slot] = 1'b0;
        hi = m_dig >> (4 * slot);
        e_seg = (blank_lz && slot != 0 && hi == 16'h0) ? 7'h7F : glyph(m_dig[4*slot +: 4]);
        e_dp = ~m_dp[slot];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".anode"}, 32'(anode), 32'(e_anode));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp"}, 32'(dp), 32'(e_dp));
    check({tag, ".fs"}, 32'(frame_start), 32'(e_fs));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_to(input int unsigned target);
    for (int n = 0; n < 400 && k < target; n++) tick();
    check("run_to_budget", k, target);
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic        lz;
    int unsigned slot;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] rd;
    int fs_gap;
    bit  seen;
    model_reset();

    // Glyph sweep through digit 0, then leading-zero cases.
    for (int v = 0; v < 16; v++) begin
      logic [6:0] g;
      case (v)
        0: g = 7'b1000000;  1: g = 7'b1111001;  2: g = 7'b0100100;  3: g = 7'b0110000;
        4: g = 7'b0011001;  5: g = 7'b0010010;  6: g = 7'b0000010;  7: g = 7'b1111000;
        8: g = 7'b0000000;  9: g = 7'b0010000;  10: g = 7'b0001000; 11: g = 7'b0000011;
        12: g = 7'b1000110; 13: g = 7'b0100001; 14: g = 7'b0000110; default: g = 7'b0001110;
      endcase
      vecs.push_back('{16'(v), 4'b0000, 1'b0, 0, 4'b1110, g, 1'b1});
    end
    vecs.push_back('{16'h0050, 4'b0010, 1'b1, 3, 4'b0111, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'b0010, 1'b1, 2, 4'b1011, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'b0010, 1'b1, 1, 4'b1101, 7'b0010010, 1'b0});
    vecs.push_back('{16'h0050, 4'b0010, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 3, 4'b0111, 7'h7F, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 1, 4'b1101, 7'h7F, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1});
    vecs.push_back('{16'h1004, 4'b0000, 1'b1, 2, 4'b1011, 7'b1000000, 1'b1});

    // Reset release with 1234.
    en = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
    do_reset();
    check("rst.anode", 32'(anode), 32'hF);
    check("rst.seg", 32'(seg), 32'h7F);
    check("rst.dp", 32'(dp), 32'h1);
    check("rst.fs", 32'(frame_start), 32'h0);
    tick();
    check("first.fs", 32'(frame_start), 32'h1);
    check("first.anode", 32'(anode), 32'hF);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("d0.anode", 32'(anode), 32'hE);
      check("d0.seg", 32'(seg), 32'(7'b0011001));
      check("d0.fs", 32'(frame_start), 32'h0);
    end
    tick();
    check("d1blank.anode", 32'(anode), 32'hF);
    tick();
    check("d1blank2.anode", 32'(anode), 32'hF);
    tick();
    check("d1.anode", 32'(anode), 32'hD);
    check("d1.seg", 32'(seg), 32'(7'b0110000));
    run_to(FRAME);
    check("frame1.fs", 32'(frame_start), 32'h1);
    fs_gap = 0; seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      fs_gap++;
      seen = frame_start;
    end
    check("frame_period", 32'(fs_gap), 32'(FRAME));

    // Mid-frame change is invisible until the next frame.
    do_reset();
    run_to(2*R + 3);
    check("mid.d2.seg", 32'(seg), 32'(7'b0100100));
    digits_in = 16'h5678;
    run_to(3*R + 2);
    check("mid.d3.anode", 32'(anode), 32'h7);
    check("mid.d3.seg", 32'(seg), 32'(7'b1111001));
    run_to(FRAME);
    check("mid.fs", 32'(frame_start), 32'h1);
    run_to(FRAME + B);
    check("mid.next.anode", 32'(anode), 32'hE);
    check("mid.next.seg", 32'(seg), 32'(7'b0000000));

    // Enable pause at cnt=4, idx=1.
    digits_in = 16'h1234;
    do_reset();
    run_to(R + 4);
    check("pause.pre", 32'(anode), 32'hD);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause.anode", 32'(anode), 32'hF);
      check("pause.seg", 32'(seg), 32'h7F);
      check("pause.dp", 32'(dp), 32'h1);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("resume.anode", 32'(anode), 32'hD);
    end
    tick();
    check("resume.end", 32'(anode), 32'hF);

    // Asynchronous reset mid-scan at cnt=5, idx=2.
    dp_in = 4'b1111;
    do_reset();
    run_to(2*R + 5);
    check("arst.pre.anode", 32'(anode), 32'hB);
    check("arst.pre.dp", 32'(dp), 32'h0);
    #2 reset = 1'b1;
    #1;
    check("arst.anode", 32'(anode), 32'hF);
    check("arst.seg", 32'(seg), 32'h7F);
    check("arst.dp", 32'(dp), 32'h1);
    digits_in = 16'h9ABC; dp_in = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
    check("arst.fs", 32'(frame_start), 32'h1);
    tick();
    check("arst.d0.anode", 32'(anode), 32'hE);
    check("arst.d0.seg", 32'(seg), 32'(7'b1000110));

    // Table vectors.
    foreach (vecs[i]) begin
      digits_in = vecs[i].dig; dp_in = vecs[i].dpv; blank_lz = vecs[i].lz;
      do_reset();
      run_to(vecs[i].slot * R + B);
      check($sformatf("vec%0d.anode", i), 32'(anode), 32'(vecs[i].exp_anode));
      check($sformatf("vec%0d.seg", i), 32'(seg), 32'(vecs[i].exp_seg));
      check($sformatf("vec%0d.dp", i), 32'(dp), 32'(vecs[i].exp_dp));
    end

    // Randomised run against the model.
    en = 1'b1; blank_lz = 1'b0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      tick();
      check_model("rand");
      if ($urandom_range(0, 9) == 0) begin
        for (int d = 0; d < 4; d++)
          rd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        digits_in = rd;
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 19) == 0) en = ~en;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
